jtopl_pg_multi: RTL and testbench

JTOPL_PG_MULTI -- requirements
Module: jtopl_pg_multi

---
 rtl/jtopl_pg_multi.sv | 148 ++++++++++++++
 tb/tb_jtopl_pg_multi.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/jtopl_pg_multi.sv
// Time-multiplexed OPL phase generator: one operator slot per cen, two-stage
// pipeline (increment calculation, then phase accumulate into per-slot storage).
module jtopl_pg_multi #(
    parameter int SLOTS = 18,
    parameter int PW    = 20,
    parameter int FNW   = 10
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           cen,
    input  logic [2:0]     block,
    input  logic [FNW-1:0] fnum,
    input  logic [3:0]     mul,
    input  logic [2:0]     lfo_mod,
    input  logic           viben,
    input  logic           vib_dep,
    input  logic           pg_rst,
    output logic [3:0]     keycode,
    output logic [9:0]     phase_op,
    output logic [4:0]     op_slot,
    output logic           op_valid
);

    localparam int SW  = $clog2(SLOTS);
    localparam int IW  = FNW + 7;
    localparam int PRW = FNW + PW + 12;

    logic [SW-1:0] r_slot;

    logic [SW-1:0] r1_slot;
    logic [3:0]    r1_mul;
    logic          r1_pg_rst;
    logic          r1_valid;
    logic [IW-1:0] r1_phinc;
    logic [3:0]    r_keycode;

    logic [PW-1:0] r_phase [SLOTS];
    logic [9:0]    r_op_phase;
    logic [SW-1:0] r_op_slot;
    logic          r_op_valid;

    logic [2:0]     w_a;
    logic [2:0]     w_m;
    logic [2:0]     w_h;
    logic [2:0]     w_pm_mag;
    logic           w_pm_neg;
    logic [FNW:0]   w_fnx;
    logic [FNW:0]   w_pm_ext;
    logic [FNW:0]   w_fm;
    logic [IW:0]    w_fm_sh;
    logic [IW-1:0]  w_phinc;
    logic [4:0]     w_mul_x2;
    logic [PRW-1:0] w_prod;
    logic [PW-1:0]  w_inc;
    logic [PW-1:0]  w_ph_cur;
    logic [PW-1:0]  w_ph_nxt;

    assign w_a = fnum[FNW-1 -: 3];

    // Vibrato offset as sign + magnitude over the 8-step triangle
    always_comb begin
        w_m      = vib_dep ? w_a : {1'b0, w_a[2:1]};
        w_h      = {1'b0, w_m[2:1]};
        w_pm_mag = 3'd0;
        w_pm_neg = 1'b0;
        if (viben) begin
            case (lfo_mod)
                3'd1, 3'd3: w_pm_mag = w_h;
                3'd2:       w_pm_mag = w_m;
                3'd5, 3'd7: begin w_pm_mag = w_h; w_pm_neg = 1'b1; end
                3'd6:       begin w_pm_mag = w_m; w_pm_neg = 1'b1; end
                default:    w_pm_mag = 3'd0;
            endcase
        end
    end

    assign w_fnx    = {fnum, 1'b0};
    assign w_pm_ext = {{(FNW-2){1'b0}}, w_pm_mag};
    assign w_fm     = w_pm_neg ? (w_fnx - w_pm_ext) : (w_fnx + w_pm_ext);
    assign w_fm_sh  = {7'd0, w_fm} << block;
    assign w_phinc  = w_fm_sh[IW:1];

    // Multiplier table stored doubled so the 0.5x code stays integral
    always_comb begin
        w_mul_x2 = 5'd1;
        case (r1_mul)
            4'd0:  w_mul_x2 = 5'd1;
            4'd1:  w_mul_x2 = 5'd2;
            4'd2:  w_mul_x2 = 5'd4;
            4'd3:  w_mul_x2 = 5'd6;
            4'd4:  w_mul_x2 = 5'd8;
            4'd5:  w_mul_x2 = 5'd10;
            4'd6:  w_mul_x2 = 5'd12;
            4'd7:  w_mul_x2 = 5'd14;
            4'd8:  w_mul_x2 = 5'd16;
            4'd9:  w_mul_x2 = 5'd18;
            4'd10: w_mul_x2 = 5'd20;
            4'd11: w_mul_x2 = 5'd20;
            4'd12: w_mul_x2 = 5'd24;
            4'd13: w_mul_x2 = 5'd24;
            4'd14: w_mul_x2 = 5'd30;
            4'd15: w_mul_x2 = 5'd30;
            default: w_mul_x2 = 5'd1;
        endcase
    end

    assign w_prod   = PRW'(r1_phinc) * PRW'(w_mul_x2);
    assign w_inc    = w_prod[PW:1];
    assign w_ph_cur = r_phase[r1_slot];
    assign w_ph_nxt = r1_pg_rst ? '0 : (w_ph_cur + w_inc);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_slot     <= '0;
            r1_slot    <= '0;
            r1_mul     <= '0;
            r1_pg_rst  <= 1'b0;
            r1_valid   <= 1'b0;
            r1_phinc   <= '0;
            r_keycode  <= '0;
            r_op_phase <= '0;
            r_op_slot  <= '0;
            r_op_valid <= 1'b0;
            for (int i = 0; i < SLOTS; i++) r_phase[i] <= '0;
        end else if (cen) begin
            r_slot    <= (r_slot == SW'(SLOTS - 1)) ? '0 : r_slot + SW'(1);
            r1_slot   <= r_slot;
            r1_mul    <= mul;
            r1_pg_rst <= pg_rst;
            r1_valid  <= 1'b1;
            r1_phinc  <= w_phinc;
            r_keycode <= {block, fnum[FNW-1]};
            r_op_valid <= r1_valid;
            // Bubble right after reset leaves storage and outputs untouched
            if (r1_valid) begin
                r_phase[r1_slot] <= w_ph_nxt;
                r_op_phase       <= w_ph_nxt[PW-1 -: 10];
                r_op_slot        <= r1_slot;
            end
        end
    end

    assign keycode  = r_keycode;
    assign phase_op = r_op_phase;
    assign op_slot  = 5'(r_op_slot);
    assign op_valid = r_op_valid;

endmodule

// File: tb/tb_jtopl_pg_multi.sv
// Scoreboard bench for jtopl_pg_multi: default instance plus a SLOTS=9/PW=22
// instance driven by the same stimulus, each checked against its own model.
module tb_jtopl_pg_multi;

    localparam int SA = 18;
    localparam int PA = 20;
    localparam int SB = 9;
    localparam int PB = 22;

    logic       clk = 1'b0;
    logic       rst;
    logic       cen;
    logic [2:0] block;
    logic [9:0] fnum;
    logic [3:0] mul;
    logic [2:0] lfo_mod;
    logic       viben;
    logic       vib_dep;
    logic       pg_rst;

    logic [3:0] kc_a, kc_b;
    logic [9:0] po_a, po_b;
    logic [4:0] sl_a, sl_b;
    logic       vl_a, vl_b;

    always #5 clk = ~clk;

    jtopl_pg_multi u_dut_a (
        .clk(clk), .rst(rst), .cen(cen), .block(block), .fnum(fnum), .mul(mul),
        .lfo_mod(lfo_mod), .viben(viben), .vib_dep(vib_dep), .pg_rst(pg_rst),
        .keycode(kc_a), .phase_op(po_a), .op_slot(sl_a), .op_valid(vl_a)
    );

    jtopl_pg_multi #(.SLOTS(SB), .PW(PB), .FNW(10)) u_dut_b (
        .clk(clk), .rst(rst), .cen(cen), .block(block), .fnum(fnum), .mul(mul),
        .lfo_mod(lfo_mod), .viben(viben), .vib_dep(vib_dep), .pg_rst(pg_rst),
        .keycode(kc_b), .phase_op(po_b), .op_slot(sl_b), .op_valid(vl_b)
    );

    int n_checks = 0;
    int n_errors = 0;

    int     mul_tbl [16] = '{1, 2, 4, 6, 8, 10, 12, 14, 16, 18, 20, 20, 24, 24, 30, 30};
    longint mph_a [32];
    longint mph_b [32];
    int     cnt_a, cnt_b;
    int     qa [$];
    int     qb [$];
    int     lk, lpa, lsa, lva, lpb, lsb, lvb;
    int     cap_slot = -1;
    int     cap_q [$];

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic longint exp_inc(input int fn, input int blk, input int ml, input int lfo,
                                       input int ve, input int vd, input int pw);
        int     a, m, h, pm, fm;
        longint phinc;
        a = (fn >> 7) & 7;
        m = (vd != 0) ? a : (a >> 1);
        h = m >> 1;
        case (lfo)
            1, 3:    pm = h;
            2:       pm = m;
            5, 7:    pm = -h;
            6:       pm = -m;
            default: pm = 0;
        endcase
        if (ve == 0) pm = 0;
        fm = (2 * fn + pm) & 'h7FF;
        phinc = (longint'(fm) << blk) >> 1;
        return ((phinc * mul_tbl[ml]) >> 1) & ((longint'(1) << pw) - 1);
    endfunction

    function automatic int op_of(input longint ph, input int pw);
        return int'((ph >> (pw - 10)) & 1023);
    endfunction

    task automatic clear_model();
        qa.delete();
        qb.delete();
        for (int i = 0; i < 32; i++) begin
            mph_a[i] = 0;
            mph_b[i] = 0;
        end
        cnt_a = 0; cnt_b = 0;
        lk = 0; lpa = 0; lsa = 0; lva = 0; lpb = 0; lsb = 0; lvb = 0;
    endtask

    task automatic step(input int blk, input int fn, input int ml, input int lfo,
                        input int ve, input int vd, input int pr);
        longint inc;
        int     e;
        @(negedge clk);
        block   = 3'(blk);
        fnum    = 10'(fn);
        mul     = 4'(ml);
        lfo_mod = 3'(lfo);
        viben   = (ve != 0);
        vib_dep = (vd != 0);
        pg_rst  = (pr != 0);
        cen     = 1'b1;
        inc = exp_inc(fn, blk, ml, lfo, ve, vd, PA);
        mph_a[cnt_a] = (pr != 0) ? 0 : ((mph_a[cnt_a] + inc) & ((longint'(1) << PA) - 1));
        qa.push_back(cnt_a * 1024 + op_of(mph_a[cnt_a], PA));
        inc = exp_inc(fn, blk, ml, lfo, ve, vd, PB);
        mph_b[cnt_b] = (pr != 0) ? 0 : ((mph_b[cnt_b] + inc) & ((longint'(1) << PB) - 1));
        qb.push_back(cnt_b * 1024 + op_of(mph_b[cnt_b], PB));
        lk = blk * 2 + ((fn >> 9) & 1);
        @(posedge clk);
        #1;
        check_val("keycode_a", kc_a, lk);
        check_val("keycode_b", kc_b, lk);
        if (qa.size() == 2) begin
            e = qa.pop_front();
            lpa = e % 1024; lsa = e / 1024; lva = 1;
            check_val("valid_a", vl_a, 1);
            check_val("phase_a", po_a, lpa);
            check_val("slot_a", sl_a, lsa);
            if (cap_slot == lsa) cap_q.push_back(int'(po_a));
        end else begin
            check_val("valid_a", vl_a, 0);
        end
        if (qb.size() == 2) begin
            e = qb.pop_front();
            lpb = e % 1024; lsb = e / 1024; lvb = 1;
            check_val("valid_b", vl_b, 1);
            check_val("phase_b", po_b, lpb);
            check_val("slot_b", sl_b, lsb);
        end else begin
            check_val("valid_b", vl_b, 0);
        end
        cnt_a = (cnt_a + 1) % SA;
        cnt_b = (cnt_b + 1) % SB;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_val("rst_kc_a", kc_a, 0);
        check_val("rst_phase_a", po_a, 0);
        check_val("rst_slot_a", sl_a, 0);
        check_val("rst_valid_a", vl_a, 0);
        check_val("rst_kc_b", kc_b, 0);
        check_val("rst_phase_b", po_b, 0);
        check_val("rst_slot_b", sl_b, 0);
        check_val("rst_valid_b", vl_b, 0);
        @(negedge clk);
        cen = 1'b0;
        rst = 1'b0;
        clear_model();
    endtask

    task automatic hold10();
        @(negedge clk);
        cen  = 1'b0;
        fnum = 10'h155;
        block = 3'd6;
        pg_rst = 1'b1;
        repeat (10) begin
            @(posedge clk);
            #1;
            check_val("hold_kc_a", kc_a, lk);
            check_val("hold_phase_a", po_a, lpa);
            check_val("hold_slot_a", sl_a, lsa);
            check_val("hold_valid_a", vl_a, lva);
            check_val("hold_phase_b", po_b, lpb);
            check_val("hold_slot_b", sl_b, lsb);
        end
    endtask

    initial begin
        rst = 1'b1; cen = 1'b0; block = '0; fnum = '0; mul = '0;
        lfo_mod = '0; viben = 1'b0; vib_dep = 1'b0; pg_rst = 1'b0;
        clear_model();
        repeat (2) @(posedge clk);
        do_reset();

        // Octave 4 / fnum 0x200 / mul 1 on every slot
        cap_slot = 0;
        cap_q.delete();
        repeat (3 * SA) step(4, 'h200, 1, 0, 0, 0, 0);
        check_val("s0_visits_mul1", cap_q.size(), 3);
        if (cap_q.size() == 3) begin
            check_val("s0_v1_mul1", cap_q[0], 'h08);
            check_val("s0_v2_mul1", cap_q[1], 'h10);
            check_val("s0_v3_mul1", cap_q[2], 'h18);
        end

        // Half multiplier
        do_reset();
        cap_q.delete();
        repeat (2 * SA) step(4, 'h200, 0, 0, 0, 0, 0);
        check_val("s0_visits_mul0", cap_q.size(), 2);
        if (cap_q.size() == 2) begin
            check_val("s0_v1_mul0", cap_q[0], 'h04);
            check_val("s0_v2_mul0", cap_q[1], 'h08);
        end
        cap_slot = -1;

        // Vibrato positive / negative peaks, shallow depth, full LFO sweep
        do_reset();
        repeat (SA) step(1, 'h380, 1, 2, 1, 1, 0);
        repeat (SA) step(1, 'h380, 1, 6, 1, 1, 0);
        repeat (SA) step(1, 'h380, 1, 2, 1, 0, 0);
        for (int i = 0; i < SA; i++) step(1, 'h380, 1, i % 8, 1, i % 2, 0);

        // Maximum increment with wrap, then a single-slot phase clear
        do_reset();
        repeat (20 * SA) step(7, 'h3FF, 15, 0, 0, 0, 0);
        cap_slot = 5;
        cap_q.delete();
        repeat (SA) step(7, 'h3FF, 15, 0, 0, 0, int'(cnt_a == 5));
        check_val("s5_clear_visits", cap_q.size(), 1);
        if (cap_q.size() == 1) check_val("s5_clear_phase", cap_q[0], 0);
        cap_slot = -1;
        repeat (SA) step(7, 'h3FF, 15, 0, 0, 0, 0);

        // Clock-enable hold and mid-frame reset
        repeat (7) step($urandom_range(0, 7), $urandom_range(0, 1023), $urandom_range(0, 15),
                        $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 1), 0);
        hold10();
        repeat (5) step(3, 'h2A5, 9, 3, 1, 1, 0);
        do_reset();
        repeat (SA + 4) step(5, 'h1C3, 7, 5, 1, 0, 0);

        // Mixed random traffic with occasional phase clears
        repeat (80) step($urandom_range(0, 7), $urandom_range(0, 1023), $urandom_range(0, 15),
                         $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 1),
                         int'($urandom_range(0, 15) == 0));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
